// File: rtl/mul11x11.sv
// Sequential 11x11 shift-add mantissa multiplier with 1.x normalization.
// Define MUL_ROUND_EN to round half-up the 10-bit mantissa instead of truncating it.
module mul11x11 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        st,
  input  logic [9:0]  f1,
  input  logic [9:0]  f2,
  output logic        done,
  output logic [10:0] f
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t      state;
  logic [21:0] acc;
  logic [21:0] mcand;
  logic [10:0] mplier;
  logic [3:0]  count;
  logic [21:0] acc_sum;
  logic [10:0] f_next;

  // Accumulator value after the current iteration; on the last RUN cycle this is the full product.
  assign acc_sum = mplier[0] ? (acc + mcand) : acc;

`ifdef MUL_ROUND_EN
  logic [10:0] rnd_low;
  logic [9:0]  rnd_high;

  assign rnd_low  = {1'b0, acc_sum[19:10]} + {10'b0, acc_sum[9]};
  assign rnd_high = (acc_sum[10] && (acc_sum[20:11] != 10'h3FF)) ? (acc_sum[20:11] + 10'd1)
                                                                 : acc_sum[20:11];

  // A carry out of the unnormalized mantissa means the rounded value reached exactly 2.0.
  always_comb begin
    f_next = 11'h000;
    if (acc_sum[21])
      f_next = {1'b1, rnd_high};
    else if (rnd_low[10])
      f_next = 11'h400;
    else
      f_next = {1'b0, rnd_low[9:0]};
  end
`else
  always_comb begin
    f_next = acc_sum[21] ? {1'b1, acc_sum[20:11]} : {1'b0, acc_sum[19:10]};
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
      f      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (st)
            state <= LOAD;
        end
        LOAD: begin
          mcand  <= {11'b0, 1'b1, f1};
          mplier <= {1'b1, f2};
          acc    <= '0;
          count  <= '0;
          state  <= RUN;
        end
        RUN: begin
          acc    <= acc_sum;
          mcand  <= {mcand[20:0], 1'b0};
          mplier <= {1'b0, mplier[10:1]};
          count  <= count + 4'd1;
          if (count == 4'd10) begin
            f     <= f_next;
            state <= DONE;
          end
        end
        DONE: begin
          if (st)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign done = (state == DONE);

endmodule

// File: doc/mul11x11.md
MUL11X11 -- requirements
Module: mul11x11

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 st  input  1  start request in IDLE; acknowledge of result in DONE.
REQ-005 f1  input  10  fraction of operand A; implicit leading 1, value 1.f1.
REQ-006 f2  input  10  fraction of operand B; implicit leading 1, value 1.f2.
REQ-007 done  output  1  high while a valid result is held and not yet acknowledged.
REQ-008 f  output  11  {ovf, mant[9:0]}; ovf=1 means the product is >= 2.0.

Function
REQ-009 The block SHALL compute P = {1,f1} x {1,f2} as a 22-bit unsigned product, where P[21:20] is the integer part.
- Multiplication is sequential shift-add: one multiplier bit per cycle, LSB first, 11 iterations.
REQ-010 The FSM SHALL have four states, IDLE, LOAD, RUN and DONE, with these transitions:
- IDLE->LOAD when st=1.
- LOAD->RUN unconditionally.
- RUN->DONE after the 11th iteration.
- DONE->IDLE when st=1.
REQ-011 In LOAD, the block SHALL capture {1,f1} and {1,f2}, clear the 22-bit accumulator and set the iteration count to 0.
- Operand changes after LOAD SHALL NOT affect the result.
REQ-012 Each RUN cycle SHALL do the following:
- if the multiplier LSB is 1, add the shifted multiplicand to the accumulator;
- shift the multiplicand left by 1 and the multiplier right by 1;
- increment the count.
REQ-013 Latency SHALL be fixed: if st is sampled at edge k, done SHALL be 1 after edge k+12, independent of the operand values.
REQ-014 On entry to DONE, f SHALL be registered as follows:
- ovf = P[21];
- mant = P[20:11] if ovf=1, else P[19:10];
- lower bits are truncated unless REQ-022 applies.
REQ-015 f SHALL hold its last value in every state until the next DONE entry.
REQ-016 done SHALL be combinationally decoded from state DONE only, and SHALL stay 1 until st is sampled high.
- After that sample, done SHALL be 0 on the next cycle.
REQ-017 st SHALL be ignored in LOAD and RUN.
REQ-018 If st is held high continuously, the block SHALL take one IDLE cycle before restarting; back-to-back results are therefore 14 cycles apart.
REQ-019 The accumulator SHALL be 22 bits wide; no carry-out of bit 21 is possible, because the maximum product is 0x3FF001.

Reset
REQ-020 When reset_n=0, the block SHALL immediately (asynchronously) force:
- state = IDLE;
- done = 0;
- f = 11'h000;
- accumulator, operand registers and count = 0.
REQ-021 Reset asserted mid-RUN SHALL abandon the operation with no partial result on f.
- The first st after reset release SHALL produce a fully correct result.

Configuration
REQ-022 Macro MUL_ROUND_EN SHALL select rounding.
- Defined: mant is rounded half-up using round bit r = P[10] if ovf=1, else P[9].
- Defined, ovf=0 and mant overflows from 10'h3FF: the result SHALL become ovf=1, mant=10'h000.
- Defined, ovf=1 and mant=10'h3FF: mant SHALL saturate at 10'h3FF.
- Undefined: truncation only, and no rounding logic SHALL be present.
- Latency SHALL be identical in both builds.

Verification
REQ-023 Unit operands: f1=10'h000, f2=10'h000, st pulse -> done after 12 edges, f=11'h000 (1.0).
REQ-024 Overflow normalization: f1=10'h200, f2=10'h200 (1.5x1.5) -> f=11'h480 (ovf=1, mant=0x080).
REQ-025 Maximum operands: f1=10'h3FF, f2=10'h3FF -> f=11'h7FE in both builds.
REQ-026 Rounding: f1=10'h001, f2=10'h200 -> f=11'h201 without MUL_ROUND_EN; f=11'h202 with it.
REQ-027 Handshake check:
- Drop st after the start; done SHALL hold high for 20 idle cycles.
- Assert st; done SHALL be 0 the next cycle and f SHALL be unchanged.
- Change f1/f2 during RUN; the result SHALL be unaffected.
REQ-028 Reset mid-operation: pull reset_n low at the 5th RUN cycle -> done=0 and f=11'h000 immediately; a restart with f1=f2=10'h200 -> f=11'h480 after 12 edges.
